// File: rtl/parser_order_scheduler.sv
// Records parser dispatch order in a small FIFO and releases parser results in that order.
// Optional protocol checker enabled by defining PARSER_ORDER_CHECK_EN.
module parser_order_scheduler #(
    parameter int unsigned NUM_PARSER = 6,
    parameter int unsigned IDX_W      = 3,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_PARSER-1:0] dispatch_valid,
    output logic                  dispatch_stall,
    input  logic [NUM_PARSER-1:0] done,
    output logic [NUM_PARSER-1:0] done_ack,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM_PARSER-1:0] out_sel,
    output logic [AW:0]           outstanding,
    output logic                  err
);

    localparam logic [AW:0] FULL      = (AW+1)'(DEPTH);
    localparam logic [AW:0] STALL_LVL = (AW+1)'(DEPTH - 2);

    logic [IDX_W-1:0] order_mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] push_idx;
    logic             any_dispatch;
    logic             push;
    logic             pop;

    // Lowest set bit wins if the one-hot rule is ever violated.
    always_comb begin
        push_idx = '0;
        for (int i = NUM_PARSER - 1; i >= 0; i--) begin
            if (dispatch_valid[i]) push_idx = IDX_W'(i);
        end
    end

    assign head = order_mem[rd_ptr];

    always_comb begin
        out_sel = '0;
        if (count != '0) begin
            for (int i = 0; i < NUM_PARSER; i++) begin
                out_sel[i] = (head == IDX_W'(i));
            end
        end
    end

    assign any_dispatch   = |dispatch_valid;
    assign out_valid      = |(out_sel & done);
    assign pop            = out_valid & out_ready;
    assign done_ack       = pop ? out_sel : '0;
    // A pop in the same cycle frees the slot, so a push at full is still accepted.
    assign push           = any_dispatch & ((count != FULL) | pop);
    assign dispatch_stall = (count >= STALL_LVL);
    assign outstanding    = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (!push && pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) order_mem[wr_ptr] <= push_idx;
    end

`ifdef PARSER_ORDER_CHECK_EN
    logic err_q;
    logic multi_hot;
    logic overflow;
    logic orphan_done;

    assign multi_hot   = |(dispatch_valid & (dispatch_valid - NUM_PARSER'(1)));
    assign overflow    = any_dispatch & (count == FULL) & ~pop;
    assign orphan_done = out_ready & ~out_valid & (count == '0) & (|done);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (multi_hot || overflow || orphan_done) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_parser_order_scheduler.sv
// Scoreboard bench for parser_order_scheduler: dispatch order queued, checked on each release.
module tb_parser_order_scheduler;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] dispatch_valid;
    logic       dispatch_stall;
    logic [5:0] done;
    logic [5:0] done_ack;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_sel;
    logic [4:0] outstanding;
    logic       err;

    int   n_total = 0;
    int   n_bad   = 0;
    int   sb_q[$];
    logic err_m;
    logic exp_multi_err;

    parser_order_scheduler #(
        .NUM_PARSER(6),
        .IDX_W     (3),
        .DEPTH     (16),
        .AW        (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dispatch_valid(dispatch_valid),
        .dispatch_stall(dispatch_stall),
        .done          (done),
        .done_ack      (done_ack),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sel       (out_sel),
        .outstanding   (outstanding),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] onehot(input int i);
        logic [5:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic int low_idx(input logic [5:0] v);
        int r;
        r = 0;
        for (int i = 5; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    // Inputs are stable here; outputs are checked mid-cycle, then the model advances.
    task automatic tick();
        logic [5:0] exp_sel;
        logic [5:0] exp_ack;
        logic       exp_valid;
        logic       exp_pop;
        logic       full;
        int         exp_idx;
        @(negedge clk);
        exp_sel   = (sb_q.size() != 0) ? onehot(sb_q[0]) : 6'd0;
        exp_valid = |(exp_sel & done);
        exp_pop   = exp_valid && out_ready;
        exp_ack   = exp_pop ? exp_sel : 6'd0;
        full      = (sb_q.size() == D);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("out_sel", 32'(out_sel), 32'(exp_sel));
        chk("done_ack", 32'(done_ack), 32'(exp_ack));
        chk("outstanding", 32'(outstanding), 32'(sb_q.size()));
        chk("stall", 32'(dispatch_stall), 32'(sb_q.size() >= D - 2));
        chk("err", 32'(err), 32'(err_m));
`ifdef PARSER_ORDER_CHECK_EN
        if ($countones(dispatch_valid) > 1) err_m = 1'b1;
        if (dispatch_valid != 0 && full && !exp_pop) err_m = 1'b1;
        if (out_ready && !exp_valid && sb_q.size() == 0 && done != 0) err_m = 1'b1;
`endif
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("order_empty", 32'(out_sel), 32'd0);
            end else begin
                exp_idx = sb_q.pop_front();
                chk("order", 32'(out_sel), 32'(onehot(exp_idx)));
            end
        end
        if (dispatch_valid != 0 && sb_q.size() < D) sb_q.push_back(low_idx(dispatch_valid));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sel"}, 32'(out_sel), 32'd0);
        chk({tag, "_ack"}, 32'(done_ack), 32'd0);
        chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
        chk({tag, "_stall"}, 32'(dispatch_stall), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        dispatch_valid = '0;
        done           = '0;
        out_ready      = 1'b0;
        err_m          = 1'b0;
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Dispatch 2,0,5; results arrive 5,0,2; release must follow dispatch order.
        out_ready = 1'b1;
        dispatch_valid = onehot(2); tick();
        dispatch_valid = onehot(0); tick();
        dispatch_valid = onehot(5); tick();
        dispatch_valid = '0;
        done = onehot(5); tick();
        done = done | onehot(0); tick();
        done = done | onehot(2);
        repeat (3) tick();
        done = '0;
        out_ready = 1'b0;
        tick();

        // Fill to full, then one dropped push.
        for (int i = 0; i < 14; i++) begin
            dispatch_valid = onehot($urandom_range(0, 5));
            tick();
        end
        chk("stall_at_14", 32'(dispatch_stall), 32'd1);
        repeat (2) begin
            dispatch_valid = onehot($urandom_range(0, 5));
            tick();
        end
        dispatch_valid = onehot(1);
        tick();
        dispatch_valid = '0;
        chk("full_outstanding", 32'(outstanding), 32'd16);

        // Push + pop at full: both accepted, count stays 16.
        done = 6'h3f;
        out_ready = 1'b1;
        dispatch_valid = onehot(4);
        tick();
        dispatch_valid = '0;
        out_ready = 1'b0;
        chk("full_pushpop", 32'(outstanding), 32'd16);

        // Mixed traffic across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 6);
            dispatch_valid = (r == 6) ? 6'd0 : onehot(r);
            done      = 6'($urandom) | 6'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        dispatch_valid = '0;
        done = 6'h3f;
        out_ready = 1'b1;
        for (int i = 0; i < 40 && sb_q.size() > 0; i++) tick();
        done = '0;
        out_ready = 1'b0;
        chk("drained", 32'(outstanding), 32'd0);

        // Head ready but downstream stalled for 3 cycles.
        dispatch_valid = onehot(1); tick();
        dispatch_valid = '0;
        done = onehot(1);
        repeat (3) tick();
        chk("hold_count", 32'(outstanding), 32'd1);
        chk("hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1; tick();
        out_ready = 1'b0;
        done = '0;
        tick();

        // Asynchronous reset with 5 entries queued.
        for (int i = 0; i < 5; i++) begin
            dispatch_valid = onehot(i);
            tick();
        end
        dispatch_valid = '0;
        chk("pre_reset_count", 32'(outstanding), 32'd5);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        sb_q.delete();
        err_m = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        dispatch_valid = onehot(3); tick();
        dispatch_valid = '0;
        done = onehot(3);
        out_ready = 1'b1;
        tick();
        done = '0;
        out_ready = 1'b0;
        tick();

        // Multi-hot dispatch: lowest bit queued, checker flags it when enabled.
        dispatch_valid = 6'b000011; tick();
        dispatch_valid = '0;
        tick();
`ifdef PARSER_ORDER_CHECK_EN
        exp_multi_err = 1'b1;
`else
        exp_multi_err = 1'b0;
`endif
        chk("err_multi", 32'(err), 32'(exp_multi_err));
        done = onehot(0);
        out_ready = 1'b1;
        tick();
        done = '0;
        out_ready = 1'b0;
        tick();
        chk("err_sticky", 32'(err), 32'(exp_multi_err));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/parser_order_scheduler.md
Name: parser_order_scheduler

Overview:
- Sits beside the slice distributor and the NUM_PARSER second-level parsers.
- Records the order in which slices are dispatched: the one-hot dispatch valid is encoded to a parser index and pushed into an order FIFO.
- Releases parser results strictly in that dispatch order, so the output stage sees slices in the original stream order.
- Throttles the distributor through a stall output before the order FIFO can overflow.

Parameters:
NUM_PARSER, 6, number of parsers; width of every one-hot vector
IDX_W, 3, width of an encoded parser index; must satisfy 2^IDX_W >= NUM_PARSER
DEPTH, 16, order FIFO entries; power of two, >= 4
AW, 4, log2(DEPTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dispatch_valid  in  NUM_PARSER  one-hot slice handoff to a parser (distributor valid_out)
dispatch_stall  out  1  stop request to the distributor
done  in  NUM_PARSER  parser i has a finished slice result waiting
done_ack  out  NUM_PARSER  one-hot; pulses for one cycle when parser i's result is consumed
out_valid  out  1  the head-of-order result is available
out_ready  in  1  downstream accepts the result
out_sel  out  NUM_PARSER  one-hot mux select for the result datapath (head parser)
outstanding  out  AW+1  dispatched but not yet consumed count
err  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - wr_ptr, rd_ptr and count cleared to 0.
  - done_ack=0, out_valid=0, out_sel=0, outstanding=0, err=0, dispatch_stall=0.
  - Reset asserted mid-operation discards all queued order entries immediately; no done_ack is issued for them.
- Push:
  - When dispatch_valid!=0 and count<DEPTH, the encoded index of the asserted bit is written at wr_ptr.
  - wr_ptr wraps modulo DEPTH; count increments.
  - A push while count==DEPTH is dropped; state is unchanged.
- Stall:
  - dispatch_stall = (count >= DEPTH-2), combinational from registered count.
  - The two-entry margin covers the distributor's one-cycle registered stop plus one in-flight dispatch.
- Pop:
  - head = entry at rd_ptr; out_sel = one-hot(head) when count!=0, else 0.
  - out_valid = (count!=0) & done[head]; combinational, so there is zero-cycle latency from done to out_valid.
  - On out_valid & out_ready: done_ack = out_sel for that cycle, rd_ptr advances modulo DEPTH, count decrements.
  - done from a non-head parser is ignored (no ack) until that parser reaches the head.
- Simultaneous push and pop in one cycle: both pointers advance and count is unchanged. This is legal at count==DEPTH because the pop frees a slot in the same cycle, so the push is accepted.
- Empty: out_valid=0, out_sel=0, done_ack=0 regardless of done.
- outstanding = count (registered).
- The same parser index may occupy multiple FIFO entries; each entry consumes exactly one done/ack handshake.
- No other latency: the index is available at the head the cycle after it is pushed.

Optional Feature:
- Macro: PARSER_ORDER_CHECK_EN.
- Defined: err is set and held until reset on any of:
  - dispatch_valid with more than one bit set (the push uses the lowest set bit);
  - a push attempted at count==DEPTH with no simultaneous pop;
  - out_ready & ~out_valid while count==0 and done!=0, i.e. a result offered from a parser with nothing dispatched.
- Undefined: the checker logic is absent; err is tied to 0. All other behaviour is identical.

Test Plan:
- Dispatch parsers 2,0,5 on consecutive cycles; assert done[5], then done[0], then done[2]; out_ready=1 -> no output until done[2]; then out_sel=000100, 000001, 100000 on successive cycles, each with a matching done_ack pulse.
- Push 14 entries with no pops (DEPTH=16) -> dispatch_stall=1 once count reaches 14; push 2 more -> count=16; a 17th push is dropped, count stays 16 and outstanding=16.
- At count=16 with a valid head, one cycle of push + out_ready -> pop accepted, push accepted, count stays 16; wr_ptr and rd_ptr both wrap past 15 to 0 correctly over 40 mixed operations against a scoreboard.
- Head ready but out_ready=0 for 3 cycles -> out_valid held at 1, done_ack=0, count unchanged; release -> exactly one ack.
- Assert rst for one cycle with 5 entries queued -> all outputs immediately 0, outstanding=0; a subsequent dispatch to parser 3 restarts cleanly.
- With PARSER_ORDER_CHECK_EN: dispatch_valid=000011 -> err=1 and stays 1; index 0 is queued. Without the macro -> err stays 0.
